// File: rtl/p_int_acc.sv
// p_int_acc: accumulates LEN consecutive multiplier products plus a bias into one neuron
// pre-activation value, then offers the saturated result on a valid/ready handshake.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - asynchronous active-high reset
//   clear     - synchronous abort; discards any partial or pending result
//   bias      - bias added once per result, sampled with the first accepted product
//   in_valid  - product valid
//   in_ready  - block accepts a product (high while accumulating)
//   in        - product value
//   in_ovf    - multiplier overflow flag for this product
//   out_valid - result valid
//   out_ready - consumer accepts the result
//   out       - saturated result
//   ovf       - overflow anywhere in this result (upstream flag or output clamp)
module p_int_acc #(
    parameter int unsigned I_PREC = 16,
    parameter int unsigned O_PREC = 16,
    parameter int unsigned B_PREC = 16,
    parameter int unsigned LEN    = 8,
    parameter bit          SIGN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [B_PREC-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [I_PREC-1:0] in,
    input  logic              in_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [O_PREC-1:0] out,
    output logic              ovf
);

    // Wide enough that LEN products plus a bias of product width never wrap.
    localparam int unsigned A_PREC = I_PREC + $clog2(LEN + 1) + 1;
    localparam int unsigned CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic [0:0] {StAcc, StOut} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [A_PREC-1:0] acc_q, acc_d;
    logic              sticky_q, sticky_d;
    logic [O_PREC-1:0] out_q, out_d;
    logic              ovf_q, ovf_d;

    logic [A_PREC-1:0] in_ext;
    logic [A_PREC-1:0] bias_ext;
    logic [A_PREC-1:0] sum;
    logic [O_PREC-1:0] sat_val;
    logic              sat_clip;

    always_comb begin
        if (SIGN) begin
            in_ext   = A_PREC'($signed(in));
            bias_ext = A_PREC'($signed(bias));
        end else begin
            in_ext   = A_PREC'(in);
            bias_ext = A_PREC'(bias);
        end
        // First product of a result starts from the bias instead of the old sum.
        sum = ((cnt_q == '0) ? bias_ext : acc_q) + in_ext;
    end

    if (O_PREC >= A_PREC) begin : g_wide
        always_comb begin
            if (SIGN) begin
                sat_val = O_PREC'($signed(sum));
            end else begin
                sat_val = O_PREC'(sum);
            end
            sat_clip = 1'b0;
        end
    end else begin : g_narrow
        always_comb begin
            sat_val  = sum[O_PREC-1:0];
            sat_clip = 1'b0;
            if (SIGN) begin
                // In range only if every bit above the output sign bit copies it.
                if (!(&sum[A_PREC-1:O_PREC-1]) && (|sum[A_PREC-1:O_PREC-1])) begin
                    sat_clip = 1'b1;
                    sat_val  = sum[A_PREC-1] ? {1'b1, {(O_PREC - 1){1'b0}}}
                                             : {1'b0, {(O_PREC - 1){1'b1}}};
                end
            end else if (|sum[A_PREC-1:O_PREC]) begin
                sat_clip = 1'b1;
                sat_val  = '1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        if (clear) begin
            // Abort beats any accept or handshake in the same cycle.
            state_d  = StAcc;
            cnt_d    = '0;
            acc_d    = '0;
            sticky_d = 1'b0;
            out_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (in_valid) begin
                        acc_d    = sum;
                        sticky_d = sticky_q | in_ovf;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = StOut;
                            out_d   = sat_val;
                            ovf_d   = sticky_q | in_ovf | sat_clip;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        state_d  = StAcc;
                        sticky_d = 1'b0;
                    end
                end
                default: state_d = StAcc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StAcc;
            cnt_q    <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StOut);
    assign out       = out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_p_int_acc.sv
// Directed bench for p_int_acc: a signed LEN=4 instance and an unsigned LEN=2 instance,
// both 8-bit products, bias and output.
module tb_p_int_acc;

    localparam int unsigned NONE = 7;

    logic clk;
    logic reset;

    // Signed instance
    logic       s_clear, s_in_valid, s_in_ready, s_in_ovf, s_out_valid, s_out_ready, s_ovf;
    logic [7:0] s_bias, s_in, s_out;

    // Unsigned instance
    logic       u_clear, u_in_valid, u_in_ready, u_in_ovf, u_out_valid, u_out_ready, u_ovf;
    logic [7:0] u_bias, u_in, u_out;

    int n_checks;
    int n_fail;

    p_int_acc #(
        .I_PREC(8), .O_PREC(8), .B_PREC(8), .LEN(4), .SIGN(1'b1)
    ) u_dut_s (
        .clk      (clk),
        .reset    (reset),
        .clear    (s_clear),
        .bias     (s_bias),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in       (s_in),
        .in_ovf   (s_in_ovf),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out      (s_out),
        .ovf      (s_ovf)
    );

    p_int_acc #(
        .I_PREC(8), .O_PREC(8), .B_PREC(8), .LEN(2), .SIGN(1'b0)
    ) u_dut_u (
        .clk      (clk),
        .reset    (reset),
        .clear    (u_clear),
        .bias     (u_bias),
        .in_valid (u_in_valid),
        .in_ready (u_in_ready),
        .in       (u_in),
        .in_ovf   (u_in_ovf),
        .out_valid(u_out_valid),
        .out_ready(u_out_ready),
        .out      (u_out),
        .ovf      (u_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       bias;
        logic [3:0][7:0]  prod;
        logic [3:0]       mask;    // in_ovf per product
        logic [2:0]       gap;     // idle cycle after this product index (NONE = no gap)
        logic [7:0]       exp_out;
        logic             exp_ovf;
    } vec_t;

    function automatic vec_t mk(input int b, input int p0, input int p1, input int p2,
                                input int p3, input int mask, input int gap,
                                input int eo, input int ev);
        vec_t v;
        v.bias    = 8'(b);
        v.prod[0] = 8'(p0);
        v.prod[1] = 8'(p1);
        v.prod[2] = 8'(p2);
        v.prod[3] = 8'(p3);
        v.mask    = 4'(mask);
        v.gap     = 3'(gap);
        v.exp_out = 8'(eo);
        v.exp_ovf = 1'(ev);
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed four products back to back; bias is only valid on the first one.
    // With drain set, out_ready is expected high and the one-cycle valid pulse is checked.
    task automatic run_s(input string tag, input vec_t v, input bit drain);
        for (int k = 0; k < 4; k++) begin
            s_bias     = (k == 0) ? v.bias : 8'hAA;
            s_in       = v.prod[k];
            s_in_ovf   = v.mask[k];
            s_in_valid = 1'b1;
            if (k == 0) check({tag, " in_ready"}, 8'(s_in_ready), 8'd1);
            if (k == 3) check({tag, " early out_valid"}, 8'(s_out_valid), 8'd0);
            tick();
            if (32'(v.gap) == k) begin
                s_in_valid = 1'b0;
                s_in       = 8'h7F;
                s_in_ovf   = 1'b1;
                tick();
            end
        end
        s_in_valid = 1'b0;
        s_in_ovf   = 1'b0;
        check({tag, " out_valid"}, 8'(s_out_valid), 8'd1);
        check({tag, " out"}, s_out, v.exp_out);
        check({tag, " ovf"}, 8'(s_ovf), 8'(v.exp_ovf));
        if (drain) begin
            tick();
            check({tag, " out_valid drop"}, 8'(s_out_valid), 8'd0);
        end
    endtask

    task automatic run_u(input string tag, input int b, input int p0, input int p1,
                         input int mask, input int eo, input int ev);
        u_bias     = 8'(b);
        u_in       = 8'(p0);
        u_in_ovf   = mask[0];
        u_in_valid = 1'b1;
        tick();
        u_bias     = 8'hAA;
        u_in       = 8'(p1);
        u_in_ovf   = mask[1];
        tick();
        u_in_valid = 1'b0;
        u_in_ovf   = 1'b0;
        check({tag, " out_valid"}, 8'(u_out_valid), 8'd1);
        check({tag, " out"}, u_out, 8'(eo));
        check({tag, " ovf"}, 8'(u_ovf), 8'(ev));
        tick();
        check({tag, " out_valid drop"}, 8'(u_out_valid), 8'd0);
    endtask

    vec_t vecs[8];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = mk(3, 10, -4, 20, 1, 0, NONE, 30, 0);
        vecs[1] = mk(0, 100, 100, 0, 0, 0, NONE, 127, 1);
        vecs[2] = mk(0, -100, -100, -100, 0, 0, NONE, -128, 1);
        vecs[3] = mk(-5, -1, -1, -1, -1, 0, 1, -9, 0);
        vecs[4] = mk(0, 127, 0, 0, 0, 0, NONE, 127, 0);
        vecs[5] = mk(-128, 0, 0, 0, 0, 0, 2, -128, 0);
        vecs[6] = mk(127, 127, 127, 127, 127, 0, NONE, 127, 1);
        vecs[7] = mk(2, 1, 2, 3, 4, 2, NONE, 12, 1);

        reset       = 1'b1;
        s_clear     = 1'b0; s_in_valid = 1'b0; s_in_ovf = 1'b0; s_out_ready = 1'b1;
        s_bias      = '0;   s_in       = '0;
        u_clear     = 1'b0; u_in_valid = 1'b0; u_in_ovf = 1'b0; u_out_ready = 1'b1;
        u_bias      = '0;   u_in       = '0;

        #3;
        check("reset s in_ready", 8'(s_in_ready), 8'd1);
        check("reset s out_valid", 8'(s_out_valid), 8'd0);
        check("reset s out", s_out, 8'd0);
        check("reset s ovf", 8'(s_ovf), 8'd0);
        check("reset u in_ready", 8'(u_in_ready), 8'd1);
        check("reset u out_valid", 8'(u_out_valid), 8'd0);
        #9;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_s($sformatf("vec%0d", i), vecs[i], 1'b1);
        end

        // Back-pressure: result held while in_valid is ignored.
        s_out_ready = 1'b0;
        run_s("bp", mk(0, 5, 5, 5, 5, 0, NONE, 20, 0), 1'b0);
        s_in_valid = 1'b1;
        s_in       = 8'd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp%0d out_valid", i), 8'(s_out_valid), 8'd1);
            check($sformatf("bp%0d out", i), s_out, 8'd20);
            check($sformatf("bp%0d in_ready", i), 8'(s_in_ready), 8'd0);
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        tick();
        check("bp release out_valid", 8'(s_out_valid), 8'd0);
        run_s("vec7", vecs[7], 1'b1);

        // Clear on the third accept: aborted products must not leak into the next result.
        s_bias = 8'd0; s_in = 8'd50; s_in_valid = 1'b1;
        tick();
        tick();
        s_clear = 1'b1;
        tick();
        s_clear    = 1'b0;
        s_in_valid = 1'b0;
        check("clr in_ready", 8'(s_in_ready), 8'd1);
        check("clr out_valid", 8'(s_out_valid), 8'd0);
        run_s("after clr", mk(1, 1, 1, 1, 1, 0, NONE, 5, 0), 1'b1);

        // Clear together with out_ready: result dropped, no second handshake.
        s_out_ready = 1'b0;
        run_s("clrhs", vecs[1], 1'b0);
        s_clear     = 1'b1;
        s_out_ready = 1'b1;
        tick();
        s_clear = 1'b0;
        check("clrhs out_valid", 8'(s_out_valid), 8'd0);
        check("clrhs out", s_out, 8'd0);
        check("clrhs ovf", 8'(s_ovf), 8'd0);
        tick();
        check("clrhs no dup", 8'(s_out_valid), 8'd0);

        // Asynchronous reset while a result is pending.
        s_out_ready = 1'b0;
        run_s("rst", vecs[1], 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("rst out_valid", 8'(s_out_valid), 8'd0);
        check("rst out", s_out, 8'd0);
        check("rst ovf", 8'(s_ovf), 8'd0);
        check("rst in_ready", 8'(s_in_ready), 8'd1);
        reset       = 1'b0;
        s_out_ready = 1'b1;
        tick();
        run_s("after rst", vecs[0], 1'b1);

        // Unsigned instance
        run_u("u0", 5, 200, 100, 0, 255, 1);
        run_u("u1", 0, 1, 2, 0, 3, 0);
        run_u("u2", 55, 100, 100, 0, 255, 0);
        run_u("u3", 0, 3, 4, 2, 7, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/p_int_acc.md
# p_int_acc

Sequential accumulator directly downstream of the integer multiplier in the perceptron datapath. It sums LEN consecutive products plus a bias into one neuron pre-activation value. It then presents the result through a valid/ready handshake, saturating to the output width and reporting overflow. Upstream it accepts one multiplier result (with its overflow flag) per cycle.

## Interface
- I_PREC, 16: width of each incoming product.
- O_PREC, 16: width of the accumulated output.
- B_PREC, 16: width of the bias input.
- LEN, 8: number of products per result; LEN ≥ 1.
- SIGN, 1: 1 means products, bias and output are two's complement; 0 means all unsigned.
- A_PREC, I_PREC + $clog2(LEN+1) + 1: internal accumulator width (derived, not overridden).
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous abort of the current accumulation.
- bias, input, B_PREC: bias added once per result; sampled on the first accepted product.
- in_valid, input, 1: product valid.
- in_ready, output, 1: block can accept a product.
- in, input, I_PREC: product value from the multiplier.
- in_ovf, input, 1: multiplier overflow flag for this product.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out, output, O_PREC: saturated result.
- ovf, output, 1: overflow occurred anywhere in this result.

## Operation
- State machine with two states.
  - ACC: in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Reset or clear:
  - state=ACC, cnt=0, acc=0, sticky ovf=0.
  - Outputs: in_ready=1, out_valid=0, out=0, ovf=0.
- Product accept: in_valid && in_ready.
  - Extend in and bias to A_PREC: sign-extend if SIGN, zero-extend otherwise.
  - If cnt==0: acc ← bias + in.
  - Otherwise: acc ← acc + in.
  - Sticky ovf |= in_ovf.
  - cnt increments.
- On accepting the product where cnt==LEN-1:
  - cnt ← 0, state ← OUT.
  - Register out and ovf from the final sum.
- Output width rules:
  - O_PREC ≥ A_PREC: out is the extended accumulator; ovf is the sticky in_ovf only.
  - O_PREC < A_PREC, signed: clamp to [-2^(O_PREC-1), 2^(O_PREC-1)-1].
  - O_PREC < A_PREC, unsigned: clamp to 2^O_PREC-1.
  - If clamping occurred, ovf=1 in addition to the sticky in_ovf.
- A_PREC is sized so the internal sum never wraps.
- OUT state:
  - out and ovf are held stable while out_valid && !out_ready.
  - On out_ready: state ← ACC, sticky ovf ← 0, out_valid drops next cycle.
  - out holds its last value after out_valid drops; consumers must not rely on it.
- clear has priority over every other event in the same cycle, including a last-product accept and an out_ready handshake.
  - The result is discarded and out_valid goes low next cycle.
- in_valid is ignored in OUT; no product is consumed.
- bias only needs to be stable in the cycle the first product is accepted.

## Timing
- Throughput: one product per cycle while in ACC.
- Latency: out_valid rises in the cycle after the last product is accepted.
- Minimum period: LEN + 1 cycles per result when out_ready is tied high (LEN accept cycles plus one OUT cycle).
- Back-pressure: each extra cycle out_ready stays low adds one cycle.
- Gaps in in_valid stall cnt and acc without altering them.
- Asynchronous reset mid-accumulation or mid-OUT forces the reset values immediately; no partial result is ever emitted.
- All outputs are registered or derived from state only: no combinational path from in_valid/out_ready to in_ready/out_valid.

## Test plan
- Signed sum, LEN=4, I_PREC=8, O_PREC=8, SIGN=1, out_ready=1:
  - Stimulus: bias=3, products 10, -4, 20, 1 on consecutive cycles.
  - Response: out=30, ovf=0, out_valid high exactly one cycle, 1 cycle after the last accept.
- Positive saturation, same configuration:
  - Stimulus: bias=0, products 100, 100, 0, 0.
  - Response: out=127, ovf=1.
- Negative saturation, same configuration:
  - Stimulus: bias=0, products -100, -100, -100, 0.
  - Response: out=-128, ovf=1.
- Back-pressure and in_ovf propagation:
  - Stimulus: out_ready low for 5 cycles after a result; in_valid held high during that time.
  - Response: out_valid stays high and out is stable; in_ready=0 and no product is consumed.
  - Stimulus: next accumulation has in_ovf=1 on product 2.
  - Response: ovf=1 even though out=12 is in range.
- Unsigned configuration, SIGN=0, LEN=2, I_PREC=8, O_PREC=8:
  - Stimulus: bias=5, products 200, 100.
  - Response: out=255, ovf=1.
  - Stimulus: next result with bias=0, products 1, 2.
  - Response: out=3, ovf=0 (sticky flag cleared).
- Abort and reset:
  - Stimulus: clear asserted on the 3rd product accept of 4.
  - Response: cnt restarts, and the next 4 products give a result that excludes the aborted products.
  - Stimulus: reset pulse while out_valid=1.
  - Response: out_valid=0, out=0, ovf=0 immediately, in_ready=1.
  - Stimulus: clear and out_ready in the same cycle.
  - Response: result dropped, no duplicate handshake.
